// File: rtl/regfile_operand_fetch.sv
// Operand fetch front end for a two-read/one-write register file.
// Issues one instruction at a time and reads its operands. It hands the
// operands to the ALU with a valid/ready handshake and forwards ALU
// writebacks to the register file. A per-register busy scoreboard stalls
// issue on RAW/WAW hazards until the pending result is written back.

package constants_pkg;
  localparam int REGISTER_ADDRESS_BITS = 3;
  localparam int REGISTER_DATA_BITS    = 8;
endpackage

module regfile_operand_fetch
  import constants_pkg::*;
#(
  parameter int ADDR_BITS = REGISTER_ADDRESS_BITS,
  parameter int DATA_BITS = REGISTER_DATA_BITS,
  localparam int NREGS    = 2 ** ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [ADDR_BITS-1:0] issue_src0,
  input  logic [ADDR_BITS-1:0] issue_src1,
  input  logic                 issue_use_src1,
  input  logic [ADDR_BITS-1:0] issue_dst,
  output logic [ADDR_BITS-1:0] rd0_addr,
  output logic [ADDR_BITS-1:0] rd1_addr,
  output logic                 rd0_enable,
  output logic                 rd1_enable,
  input  logic [DATA_BITS-1:0] rd0_data,
  input  logic [DATA_BITS-1:0] rd1_data,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic                 wr_enable,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [DATA_BITS-1:0] op_a,
  output logic [DATA_BITS-1:0] op_b,
  output logic [ADDR_BITS-1:0] op_dst,
  input  logic                 wb_valid,
  input  logic [ADDR_BITS-1:0] wb_dst,
  input  logic [DATA_BITS-1:0] wb_data,
  output logic [NREGS-1:0]     busy,
  output logic                 wb_error
);

  typedef enum logic [1:0] {IDLE, READ, PRESENT} state_t;

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] src0, src1;
  logic                 use_src1;
  logic [NREGS-1:0]     wb_mask;
  logic [NREGS-1:0]     eff_busy;
  logic                 hazard;
  logic                 accept;

  // A writeback in this cycle commits at the same edge as an accept, so its
  // busy bit no longer blocks issue.
  assign wb_mask  = wb_valid ? (NREGS'(1) << wb_dst) : '0;
  assign eff_busy = busy & ~wb_mask;
  assign hazard   = eff_busy[issue_src0]
                  | (issue_use_src1 & eff_busy[issue_src1])
                  | eff_busy[issue_dst];

  // Writeback is a straight combinational pass-through to the write port.
  assign wr_enable = wb_valid;
  assign wr_addr   = wb_dst;
  assign wr_data   = wb_data;

  // Read ports are only enabled during the single READ cycle.
  assign rd0_addr   = src0;
  assign rd1_addr   = src1;
  assign rd0_enable = (state == READ);
  assign rd1_enable = (state == READ) & use_src1;

  assign op_valid = (state == PRESENT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and issue handshake.
  always_comb begin
    state_next  = state;
    issue_ready = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        issue_ready = !hazard;
        accept      = issue_valid & !hazard;
        if (accept) state_next = READ;
      end
      READ:    state_next = PRESENT;
      PRESENT: if (op_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the accepted instruction; capture operands at the end of READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src0     <= '0;
      src1     <= '0;
      use_src1 <= 1'b0;
      op_dst   <= '0;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      if (accept) begin
        src0     <= issue_src0;
        src1     <= issue_src1;
        use_src1 <= issue_use_src1;
        op_dst   <= issue_dst;
      end
      if (state == READ) begin
        op_a <= rd0_data;
        op_b <= use_src1 ? rd1_data : '0;
      end
    end
  end

  // Busy scoreboard: writeback clears, accept sets (set wins on a tie).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~wb_mask) | (accept ? (NREGS'(1) << issue_dst) : '0);
    end
  end

  // Sticky flag for writebacks to registers with no pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          wb_error <= 1'b0;
    else if (wb_valid && !busy[wb_dst]) wb_error <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Scoreboard bench for regfile_operand_fetch: a behavioural register file
// answers the read ports, expected operands are queued at accept and
// compared when the ALU handshake completes.
module tb_regfile_operand_fetch;
  localparam int AB = 3;
  localparam int DB = 8;
  localparam int NR = 2 ** AB;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid, issue_ready, issue_use_src1;
  logic [AB-1:0] issue_src0, issue_src1, issue_dst;
  logic [AB-1:0] rd0_addr, rd1_addr, wr_addr, op_dst, wb_dst;
  logic          rd0_enable, rd1_enable, wr_enable, op_valid, op_ready, wb_valid, wb_error;
  logic [DB-1:0] rd0_data, rd1_data, wr_data, op_a, op_b, wb_data;
  logic [NR-1:0] busy;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;

  typedef struct packed {
    logic [DB-1:0] a;
    logic [DB-1:0] b;
    logic [AB-1:0] dst;
  } exp_t;
  exp_t exp_q[$];

  logic [DB-1:0] rf_mem  [NR] = '{default: '0};
  logic [DB-1:0] exp_regs[NR] = '{default: '0};

  regfile_operand_fetch #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_src0(issue_src0), .issue_src1(issue_src1),
    .issue_use_src1(issue_use_src1), .issue_dst(issue_dst),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
    .rd0_enable(rd0_enable), .rd1_enable(rd1_enable),
    .rd0_data(rd0_data), .rd1_data(rd1_data),
    .wr_addr(wr_addr), .wr_enable(wr_enable), .wr_data(wr_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_dst(op_dst),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .busy(busy), .wb_error(wb_error)
  );

  always #5 clk = ~clk;

  // Register file: asynchronous read, write on the rising edge.
  always @(posedge clk) if (wr_enable) rf_mem[wr_addr] <= wr_data;
  assign rd0_data = rf_mem[rd0_addr];
  assign rd1_data = rf_mem[rd1_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [AB-1:0] d, input logic [DB-1:0] v);
    wb_valid = 1'b1; wb_dst = d; wb_data = v;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic drive_issue(input logic [AB-1:0] s0, input logic [AB-1:0] s1,
                             input logic u1, input logic [AB-1:0] d);
    issue_valid = 1'b1; issue_src0 = s0; issue_src1 = s1;
    issue_use_src1 = u1; issue_dst = d;
  endtask

  // Monitor between edges: model writebacks, push at accept, pop at handshake.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (op_valid && op_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          pops++;
          check("sb_op_a", 32'(op_a), 32'(e.a));
          check("sb_op_b", 32'(op_b), 32'(e.b));
          check("sb_op_dst", 32'(op_dst), 32'(e.dst));
        end
      end
      if (wb_valid) exp_regs[wb_dst] = wb_data;
      if (issue_valid && issue_ready) begin
        exp_t e;
        e.a   = exp_regs[issue_src0];
        e.b   = issue_use_src1 ? exp_regs[issue_src1] : '0;
        e.dst = issue_dst;
        exp_q.push_back(e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; issue_valid = 1'b0; op_ready = 1'b1; wb_valid = 1'b0;
    issue_src0 = '0; issue_src1 = '0; issue_use_src1 = 1'b0; issue_dst = '0;
    wb_dst = '0; wb_data = '0;
    #2;
    check("rst_op_valid", 32'(op_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_issue_ready", 32'(issue_ready), 1);
    check("rst_rd0_enable", 32'(rd0_enable), 0);
    tick(); tick();
    reset = 1'b0;

    // Preload r2/r5 and one spurious write; all are spurious after reset.
    wb_valid = 1'b1; wb_dst = 3'd6; wb_data = 8'h66;
    #1;
    check("spur_wr_enable", 32'(wr_enable), 1);
    check("spur_wr_addr", 32'(wr_addr), 6);
    tick(); wb_valid = 1'b0;
    check("spur_wb_error", 32'(wb_error), 1);
    wb(3'd2, 8'h11);
    wb(3'd5, 8'h22);
    check("wb_error_sticky", 32'(wb_error), 1);
    #2 reset = 1'b1;
    #1 check("async_rst_wb_error", 32'(wb_error), 0);
    tick(); reset = 1'b0;

    // Basic fetch.
    op_ready = 1'b0;
    drive_issue(3'd2, 3'd5, 1'b1, 3'd3);
    #1 check("basic_issue_ready", 32'(issue_ready), 1);
    tick(); issue_valid = 1'b0;
    check("basic_rd0_enable", 32'(rd0_enable), 1);
    check("basic_rd0_addr", 32'(rd0_addr), 2);
    check("basic_rd1_enable", 32'(rd1_enable), 1);
    check("basic_rd1_addr", 32'(rd1_addr), 5);
    check("basic_op_valid_read", 32'(op_valid), 0);
    check("basic_busy", 32'(busy), 32'h08);
    tick();
    check("basic_op_valid", 32'(op_valid), 1);
    check("basic_rd0_enable_off", 32'(rd0_enable), 0);
    check("basic_op_a", 32'(op_a), 32'h11);
    check("basic_op_b", 32'(op_b), 32'h22);
    op_ready = 1'b1;
    tick();
    check("basic_back_idle", 32'(op_valid), 0);

    // RAW stall on r3 until its writeback arrives.
    drive_issue(3'd3, 3'd0, 1'b0, 3'd1);
    #1 check("raw_stall0", 32'(issue_ready), 0);
    tick(); check("raw_stall1", 32'(issue_ready), 0);
    tick(); check("raw_stall2", 32'(issue_ready), 0);
    wb_valid = 1'b1; wb_dst = 3'd3; wb_data = 8'h7E;
    #1 check("raw_release", 32'(issue_ready), 1);
    tick(); issue_valid = 1'b0; wb_valid = 1'b0;
    check("raw_busy", 32'(busy), 32'h02);
    tick();
    check("raw_op_a", 32'(op_a), 32'h7E);
    check("raw_op_b", 32'(op_b), 0);
    tick();

    // WAW with same-cycle set/clear on r4.
    drive_issue(3'd2, 3'd0, 1'b0, 3'd4);
    tick(); issue_valid = 1'b0; tick(); tick();
    check("waw_busy_pre", 32'(busy), 32'h12);
    drive_issue(3'd5, 3'd0, 1'b0, 3'd4);
    wb_valid = 1'b1; wb_dst = 3'd4; wb_data = 8'h44;
    #1 check("waw_issue_ready", 32'(issue_ready), 1);
    tick(); issue_valid = 1'b0; wb_valid = 1'b0;
    check("waw_busy_post", 32'(busy), 32'h12);
    tick(); tick();
    wb(3'd4, 8'h45);
    wb(3'd1, 8'h10);
    check("waw_busy_clear", 32'(busy), 0);

    // Single source with backpressure.
    op_ready = 1'b0;
    drive_issue(3'd5, 3'd2, 1'b0, 3'd7);
    tick();
    drive_issue(3'd0, 3'd0, 1'b0, 3'd0);
    check("single_rd1_enable", 32'(rd1_enable), 0);
    check("single_rd0_enable", 32'(rd0_enable), 1);
    check("single_rd0_addr", 32'(rd0_addr), 5);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_op_valid", i), 32'(op_valid), 1);
      check($sformatf("bp%0d_op_a", i), 32'(op_a), 32'h22);
      check($sformatf("bp%0d_op_b", i), 32'(op_b), 0);
      check($sformatf("bp%0d_issue_ready", i), 32'(issue_ready), 0);
      tick();
    end
    op_ready = 1'b1;
    tick();
    check("bp_idle_op_valid", 32'(op_valid), 0);
    check("bp_idle_issue_ready", 32'(issue_ready), 1);
    issue_valid = 1'b0;

    // Reset in PRESENT with busy = 8'h05 and wb_error set.
    wb(3'd7, 8'h70);
    drive_issue(3'd6, 3'd0, 1'b0, 3'd0);
    tick(); issue_valid = 1'b0; tick(); tick();
    op_ready = 1'b0;
    drive_issue(3'd5, 3'd0, 1'b0, 3'd2);
    tick(); issue_valid = 1'b0; tick();
    check("rmid_busy", 32'(busy), 32'h05);
    check("rmid_op_valid", 32'(op_valid), 1);
    wb_valid = 1'b1; wb_dst = 3'd6; wb_data = 8'h99;
    #1 check("rmid_wr_data", 32'(wr_data), 32'h99);
    tick(); wb_valid = 1'b0;
    check("rmid_wb_error", 32'(wb_error), 1);
    #2 reset = 1'b1;
    #1;
    check("rmid_rst_op_valid", 32'(op_valid), 0);
    check("rmid_rst_busy", 32'(busy), 0);
    check("rmid_rst_issue_ready", 32'(issue_ready), 1);
    check("rmid_rst_wb_error", 32'(wb_error), 0);
    check("rmid_rst_op_a", 32'(op_a), 0);
    tick(); reset = 1'b0; op_ready = 1'b1;
    tick();
    check("sb_pop_count", 32'(pops), 6);
    check("sb_queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
